vga_pixel_out: RTL and testbench
================================

// Module: vga_pixel_out
// PURPOSE
//  Downstream stage of the VGA timing/address generator. Turns its re/raddr fetch requests into
//  synchronous board-RAM reads and double-buffers the returned 2-bit tile state. It swaps that state
//  in on update_state and maps it through a 4-entry palette. Drives registered rgb/hsync/vsync pins
//  with all outputs aligned, plus a frame_done pulse telling game logic the board RAM is free.
// PARAMETERS
//  RGB_W     4         bits per colour channel (rgb port is 3*RGB_W)
//  PIPE_DLY  2         cycles from row/col input to aligned pin outputs (fixed by design, checked)
//  PAL0..3   12'h000/12'h0F0/12'hF00/12'hFF0   palette for EMPTY/BODY/FOOD/HEAD
// PORTS
//  clk           in   1        pixel clock (25.175 MHz domain)
//  reset         in   1        asynchronous, active-high
//  row           in   10       horizontal pixel counter, 0..HFULLSCAN-1
//  col           in   10       line counter, 0..VFULLSCAN-1
//  re            in   1        fetch request, one-cycle pulse
//  raddr         in   10       {hblock[4:0], vblock[4:0]} tile address, valid with re
//  update_state  in   1        pulse: promote fetched tile to current
//  updateoutput  in   1        pulse: recompute colour register from current tile
//  ram_re        out  1        board RAM read enable
//  ram_addr      out  10       board RAM address
//  ram_rdata     in   2        tile state, valid the cycle after ram_re (sync BRAM)
//  rgb           out  3*RGB_W  pixel colour, {R,G,B}
//  hsync, vsync  out  1        active-low sync
//  frame_done    out  1        one-cycle pulse, last pixel of frame
//  fetch_err     out  1        sticky: update_state seen with no pending fetch
// BEHAVIOUR
//  - Reset (async): ram_re=0, ram_addr=0, rgb=0, hsync=vsync=1, frame_done=0, fetch_err=0,
//    pend_valid=0, cur_tile=EMPTY, colour reg=0.
//  - Fetch: ram_re/ram_addr are registered copies of re/raddr (1 cycle). Cycle after ram_re,
//    ram_rdata->pend_tile, pend_valid<=1. Total re->pend_valid latency = 2 cycles.
//  - Promote: on update_state: if pend_valid (or being set this cycle, bypass ram_rdata) then
//    cur_tile<=pending, pend_valid<=0; else cur_tile holds and fetch_err<=1 (clears only on reset).
//  - Simultaneous re and update_state: promote uses prior pending; new fetch proceeds unaffected.
//    Second re before promote overwrites pending (last fetch wins, no error).
//  - Colour stage (stage 1): active_d1=(row<HACTIVE)&(col<VACTIVE). If !active_d1 colour<=0;
//    else if updateoutput colour<=PAL[cur_tile]; else hold.
//  - Sync stage 1: hs_d1 = !(row in [HSYNC_START, HSYNC_END)), vs_d1 = !(col in [VSYNC_START,
//    VSYNC_END)). Stage 2: rgb/hsync/vsync registered from stage-1 values -> PIPE_DLY=2 for all.
//  - frame_done: registered (row==HFULLSCAN-1)&(col==VFULLSCAN-1), so asserted one cycle after that
//    pixel; exactly one pulse per frame.
//  - Out-of-range row/col (>= FULLSCAN): treated as blanking, syncs deasserted; no error.
//  - Reset mid-frame: all pipeline state cleared immediately; first post-reset frame may show EMPTY
//    tiles until the first promote; no X on any output.
// STRUCTURE
//  - vga_params.sv gains: typedef enum logic [1:0] {TILE_EMPTY, TILE_BODY, TILE_FOOD, TILE_HEAD}
//    tile_state_t; HSYNC_START/HSYNC_END/VSYNC_START/VSYNC_END derived from HACTIVE/porches.
//  - One sub-module: vga_sync_gen (row/col -> registered hs/vs/active/frame_done, 1 cycle) so the
//    sync timing is unit-testable alone. Fetch buffer, promote and palette stay inline.
//  - Use existing flopr/flopenr for pipeline registers; all flops async-reset on reset.
// TESTING
//  1 Reset released, row/col free-running from 0 -> hsync low exactly for row 656..751 (+2 cycles),
//    vsync low for col 490..491, rgb=0 everywhere, frame_done once at row=799,col=524.
//  2 re@raddr=10'h2A3 cycle t, model returns 2'b10 at t+2; update_state t+3, updateoutput t+4, pixel
//    active -> ram_addr=10'h2A3 at t+1, rgb=12'hF00 at t+6.
//  3 update_state with no prior re -> cur_tile unchanged, fetch_err=1 next cycle, stays 1 until reset.
//  4 re at t and t+1 (data 01 then 11), single update_state at t+4 -> HEAD colour 12'hFF0 shown,
//    no fetch_err.
//  5 Active tile BODY, row crosses 640 -> rgb=0 from row 642 aligned with blank; back to 12'h0F0
//    when next line's first updateoutput lands.
//  6 Assert reset for 3 cycles mid-line at row=300 -> all outputs at reset values same cycle
//    (async), no X after release.

Source files
------------

// File: rtl/vga_pixel_out_pkg.sv
// Shared VGA 640x480@60 timing constants and tile types for the pixel output stage.
package vga_pixel_out_pkg;

    localparam int HACTIVE = 640;
    localparam int HFRONT  = 16;
    localparam int HSYNC_W = 96;
    localparam int HBACK   = 48;
    localparam int HFULLSCAN = HACTIVE + HFRONT + HSYNC_W + HBACK;

    localparam int VACTIVE = 480;
    localparam int VFRONT  = 10;
    localparam int VSYNC_W = 2;
    localparam int VBACK   = 33;
    localparam int VFULLSCAN = VACTIVE + VFRONT + VSYNC_W + VBACK;

    localparam logic [9:0] H_ACT       = 10'(HACTIVE);
    localparam logic [9:0] V_ACT       = 10'(VACTIVE);
    localparam logic [9:0] HSYNC_START = 10'(HACTIVE + HFRONT);
    localparam logic [9:0] HSYNC_END   = 10'(HACTIVE + HFRONT + HSYNC_W);
    localparam logic [9:0] VSYNC_START = 10'(VACTIVE + VFRONT);
    localparam logic [9:0] VSYNC_END   = 10'(VACTIVE + VFRONT + VSYNC_W);
    localparam logic [9:0] H_LAST      = 10'(HFULLSCAN - 1);
    localparam logic [9:0] V_LAST      = 10'(VFULLSCAN - 1);

    typedef enum logic [1:0] {
        TILE_EMPTY,
        TILE_BODY,
        TILE_FOOD,
        TILE_HEAD
    } tile_state_t;

    // Half-open interval test: lo <= v < hi.
    function automatic logic in_span(
        input logic [9:0] v,
        input logic [9:0] lo,
        input logic [9:0] hi
    );
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_pixel_out_sync_gen.sv
// Row/col to registered active-low syncs and end-of-frame pulse (one cycle),
// plus the combinational active-area flag used by the colour stage.
module vga_pixel_out_sync_gen
    import vga_pixel_out_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] row,
    input  logic [9:0] col,
    output logic       hs,
    output logic       vs,
    output logic       active,
    output logic       frame_done
);

    assign active = (row < H_ACT) && (col < V_ACT);

    // Out-of-range counters fall outside both sync windows, so syncs stay high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs         <= 1'b1;
            vs         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            hs         <= !in_span(row, HSYNC_START, HSYNC_END);
            vs         <= !in_span(col, VSYNC_START, VSYNC_END);
            frame_done <= (row == H_LAST) && (col == V_LAST);
        end
    end

endmodule

// File: rtl/vga_pixel_out.sv
// VGA pixel output stage: board-RAM tile fetch, double-buffered tile state,
// palette lookup and aligned registered rgb/hsync/vsync pins.
module vga_pixel_out
    import vga_pixel_out_pkg::*;
#(
    parameter int RGB_W    = 4,
    parameter int PIPE_DLY = 2,
    parameter logic [3*RGB_W-1:0] PAL0 = 12'h000,
    parameter logic [3*RGB_W-1:0] PAL1 = 12'h0F0,
    parameter logic [3*RGB_W-1:0] PAL2 = 12'hF00,
    parameter logic [3*RGB_W-1:0] PAL3 = 12'hFF0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         row,
    input  logic [9:0]         col,
    input  logic               re,
    input  logic [9:0]         raddr,
    input  logic               update_state,
    input  logic               updateoutput,
    output logic               ram_re,
    output logic [9:0]         ram_addr,
    input  logic [1:0]         ram_rdata,
    output logic [3*RGB_W-1:0] rgb,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_done,
    output logic               fetch_err
);

    localparam int CW = 3 * RGB_W;
    localparam int OW = CW + 2;
    localparam int OUT_STAGES = PIPE_DLY - 1;
    localparam logic [OW-1:0] OUT_IDLE = {{CW{1'b0}}, 2'b11};

    logic        hs_d1;
    logic        vs_d1;
    logic        active;
    logic        rd_vld;
    logic        pend_valid;
    logic        have_tile;
    tile_state_t pend_tile;
    tile_state_t cur_tile;
    tile_state_t rd_tile;
    logic [CW-1:0] colour;
    logic [CW-1:0] pal_colour;
    logic [OW-1:0] out_pipe [OUT_STAGES];

    vga_pixel_out_sync_gen u_sync (
        .clk        (clk),
        .reset      (reset),
        .row        (row),
        .col        (col),
        .hs         (hs_d1),
        .vs         (vs_d1),
        .active     (active),
        .frame_done (frame_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_re   <= 1'b0;
            ram_addr <= '0;
            rd_vld   <= 1'b0;
        end else begin
            ram_re   <= re;
            ram_addr <= raddr;
            rd_vld   <= ram_re;
        end
    end

    assign rd_tile   = tile_state_t'(ram_rdata);
    assign have_tile = pend_valid | rd_vld;

    // Data landing this cycle bypasses the pending register on a promote.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_tile  <= TILE_EMPTY;
            pend_valid <= 1'b0;
            cur_tile   <= TILE_EMPTY;
            fetch_err  <= 1'b0;
        end else begin
            if (rd_vld)
                pend_tile <= rd_tile;
            if (update_state)
                pend_valid <= 1'b0;
            else if (rd_vld)
                pend_valid <= 1'b1;
            if (update_state && have_tile)
                cur_tile <= rd_vld ? rd_tile : pend_tile;
            if (update_state && !have_tile)
                fetch_err <= 1'b1;
        end
    end

    always_comb begin
        pal_colour = PAL0;
        unique case (cur_tile)
            TILE_EMPTY: pal_colour = PAL0;
            TILE_BODY:  pal_colour = PAL1;
            TILE_FOOD:  pal_colour = PAL2;
            TILE_HEAD:  pal_colour = PAL3;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            colour <= '0;
        else if (!active)
            colour <= '0;
        else if (updateoutput)
            colour <= pal_colour;
    end

    // Colour and syncs leave stage 1 together so the pins stay aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < OUT_STAGES; i++)
                out_pipe[i] <= OUT_IDLE;
        end else begin
            out_pipe[0] <= {colour, hs_d1, vs_d1};
            for (int i = 1; i < OUT_STAGES; i++)
                out_pipe[i] <= out_pipe[i-1];
        end
    end

    assign {rgb, hsync, vsync} = out_pipe[OUT_STAGES-1];

endmodule

// File: tb/tb_vga_pixel_out.sv
// Randomized scoreboard bench for vga_pixel_out against a transaction-level
// model of fetch/promote/palette and VGA 640x480 sync timing.
module tb_vga_pixel_out;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  row;
    logic [9:0]  col;
    logic        re;
    logic [9:0]  raddr;
    logic        update_state;
    logic        updateoutput;
    logic        ram_re;
    logic [9:0]  ram_addr;
    logic [1:0]  ram_rdata = 2'b00;
    logic [11:0] rgb;
    logic        hsync;
    logic        vsync;
    logic        frame_done;
    logic        fetch_err;

    vga_pixel_out dut (
        .clk          (clk),
        .reset        (reset),
        .row          (row),
        .col          (col),
        .re           (re),
        .raddr        (raddr),
        .update_state (update_state),
        .updateoutput (updateoutput),
        .ram_re       (ram_re),
        .ram_addr     (ram_addr),
        .ram_rdata    (ram_rdata),
        .rgb          (rgb),
        .hsync        (hsync),
        .vsync        (vsync),
        .frame_done   (frame_done),
        .fetch_err    (fetch_err)
    );

    always #5 clk = ~clk;

    // Synchronous board RAM
    logic [1:0] mem [1024];
    always @(posedge clk)
        if (ram_re) ram_rdata <= mem[ram_addr];

    typedef struct {
        int         due;
        logic       re;
        logic [9:0] addr;
        logic       fd;
        logic       err;
    } e1_t;

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } e2_t;

    typedef struct {
        int         avail;
        logic [1:0] v;
    } f_t;

    e1_t q1[$];
    e2_t q2[$];
    f_t  fq[$];

    logic [11:0] pal_tab [4] = '{12'h000, 12'h0F0, 12'hF00, 12'hFF0};

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    logic [1:0]  m_cur = 2'b00;
    logic [11:0] m_col = 12'h000;
    logic        m_err = 1'b0;
    logic        in_rst = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [11:0] act,
                       input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        e1_t a;
        e2_t b;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            a = q1.pop_front();
            chk("ram_re", {11'd0, ram_re}, {11'd0, a.re});
            chk("ram_addr", {2'd0, ram_addr}, {2'd0, a.addr});
            chk("frame_done", {11'd0, frame_done}, {11'd0, a.fd});
            chk("fetch_err", {11'd0, fetch_err}, {11'd0, a.err});
        end
        if (q2.size() > 0 && q2[0].due == cyc) begin
            b = q2.pop_front();
            chk("rgb", rgb, b.rgb);
            chk("hsync", {11'd0, hsync}, {11'd0, b.hs});
            chk("vsync", {11'd0, vsync}, {11'd0, b.vs});
        end
    end

    task automatic step(input logic r, input logic [9:0] rw,
                        input logic [9:0] cl, input logic re_i,
                        input logic [9:0] ad, input logic up,
                        input logic uo);
        logic act;
        logic hs;
        logic vs;
        logic got;
        logic [1:0] last;
        f_t tmp;
        @(posedge clk);
        #1;
        reset = r;
        row = rw;
        col = cl;
        re = re_i;
        raddr = ad;
        update_state = up;
        updateoutput = uo;
        if (r) begin
            if (!in_rst) begin
                q1.delete();
                q2.delete();
                fq.delete();
                #1;
                chk("rst_rgb", rgb, 12'h000);
                chk("rst_hsync", {11'd0, hsync}, 12'd1);
                chk("rst_vsync", {11'd0, vsync}, 12'd1);
                chk("rst_frame_done", {11'd0, frame_done}, 12'd0);
                chk("rst_fetch_err", {11'd0, fetch_err}, 12'd0);
                chk("rst_ram_re", {11'd0, ram_re}, 12'd0);
                chk("rst_ram_addr", {2'd0, ram_addr}, 12'd0);
            end
            in_rst = 1'b1;
            m_cur = 2'b00;
            m_col = 12'h000;
            m_err = 1'b0;
            q1.push_back('{cyc + 1, 1'b0, 10'd0, 1'b0, 1'b0});
            q2.push_back('{cyc + 2, 12'h000, 1'b1, 1'b1});
        end else begin
            in_rst = 1'b0;
            act = (rw < 640) && (cl < 480);
            hs = !((rw >= 656) && (rw < 752));
            vs = !((cl == 490) || (cl == 491));
            if (!act)
                m_col = 12'h000;
            else if (uo)
                m_col = pal_tab[m_cur];
            // Promote takes the newest fetch whose data has arrived.
            if (up) begin
                got = 1'b0;
                last = 2'b00;
                while (fq.size() > 0 && fq[0].avail <= cyc) begin
                    tmp = fq.pop_front();
                    last = tmp.v;
                    got = 1'b1;
                end
                if (got)
                    m_cur = last;
                else
                    m_err = 1'b1;
            end
            if (re_i)
                fq.push_back('{cyc + 2, mem[ad]});
            q1.push_back('{cyc + 1, re_i, ad,
                           (rw == 799) && (cl == 524), m_err});
            q2.push_back('{cyc + 2, m_col, hs, vs});
        end
    endtask

    task automatic line_rand(input logic [9:0] cl, input int first,
                             input int last);
        for (int r = first; r < last; r++)
            step(1'b0, 10'(r), cl,
                 $urandom_range(0, 7) == 0, 10'($urandom),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
    endtask

    int cols [9] = '{11, 479, 480, 489, 490, 491, 492, 524, 600};

    initial begin
        logic       e;
        logic       u;
        logic       o;
        logic [9:0] a;
        reset = 1'b1;
        row = '0;
        col = '0;
        re = 1'b0;
        raddr = '0;
        update_state = 1'b0;
        updateoutput = 1'b0;
        for (int i = 0; i < 1024; i++)
            mem[i] = 2'($urandom);
        mem[10'h2A3] = 2'b10;
        mem[10'h00A] = 2'b01;
        mem[10'h00B] = 2'b11;
        mem[10'h00C] = 2'b01;

        repeat (3) step(1'b1, 10'd0, 10'd0, 1'b0, 10'd0, 1'b0, 1'b0);

        // Directed line: single fetch, last-fetch-wins, orphan promote,
        // then a BODY tile running into horizontal blanking.
        for (int r = 0; r < 800; r++) begin
            e = (r == 100) || (r == 200) || (r == 201) || (r == 400);
            a = (r == 100) ? 10'h2A3 : (r == 200) ? 10'h00A :
                (r == 201) ? 10'h00B : (r == 400) ? 10'h00C : 10'h000;
            u = (r == 103) || (r == 204) || (r == 300) || (r == 403);
            o = (r == 104) || (r == 205) || (r == 301) || (r >= 404);
            step(1'b0, 10'(r), 10'd10, e, a, u, o);
        end
        for (int r = 0; r < 8; r++)
            step(1'b0, 10'(r), 10'd11, 1'b0, 10'd0, 1'b0, 1'b1);

        for (int i = 0; i < 9; i++)
            line_rand(10'(cols[i]), 0, (cols[i] == 600) ? 1024 : 800);

        line_rand(10'd20, 0, 300);
        repeat (3) step(1'b1, 10'd300, 10'd20, 1'b0, 10'd0, 1'b0, 1'b0);
        line_rand(10'd20, 303, 800);

        repeat (3) line_rand(10'($urandom_range(0, 530)), 0, 800);
        repeat (4) step(1'b0, 10'd700, 10'd500, 1'b0, 10'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
